// File: rtl/mac8_seq_ctrl.sv
// Sequential 8x8 unsigned multiply-accumulate built from a single 2x2 multiplier cell.
// Define MAC8_SEQ_CTRL_SATURATE_EN for a saturating accumulator; the default build wraps.

module mult2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic c1;

    // Gate-level 2x2 product: two partial-product columns with one carry between them.
    assign c1   = (x[1] & y[0]) & (x[0] & y[1]);
    assign p[0] = x[0] & y[0];
    assign p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    assign p[2] = (x[1] & y[1]) ^ c1;
    assign p[3] = (x[1] & y[1]) & c1;
endmodule

module mac8_seq_ctrl #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, RUN, ACCUM, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  a_r, b_r;
    logic [3:0]  cnt;
    logic [15:0] product;
    logic [1:0]  a_sel, b_sel;
    logic [2:0]  ij;
    logic [3:0]  pp;
    logic [15:0] pp_sh;
    logic [ACC_W:0] sum;

    // cnt walks all 16 digit pairs: high bits pick the a digit, low bits the b digit.
    assign a_sel = a_r[{cnt[3:2], 1'b0} +: 2];
    assign b_sel = b_r[{cnt[1:0], 1'b0} +: 2];
    assign ij    = {1'b0, cnt[3:2]} + {1'b0, cnt[1:0]};
    assign pp_sh = 16'(pp) << {ij, 1'b0};
    assign sum   = {1'b0, acc} + (ACC_W+1)'(product);

    mult2x2 u_mult (
        .x (a_sel),
        .y (b_sel),
        .p (pp)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 4'd15) state_nxt = ACCUM;
            ACCUM:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            cnt     <= '0;
            product <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        product <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    product <= product + pp_sh;
                    cnt     <= cnt + 4'd1;
                end
                ACCUM: begin
`ifdef MAC8_SEQ_CTRL_SATURATE_EN
                    if (sum[ACC_W]) begin
                        acc <= '1;
                        ovf <= 1'b1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
`else
                    acc <= sum[ACC_W-1:0];
                    if (sum[ACC_W]) ovf <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// Directed bench for mac8_seq_ctrl: a 20-bit instance for the main scenarios, a 16-bit one for overflow.

module tb_mac8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, start16, clr;
    logic [7:0]  a, b;
    logic        busy, done, ovf;
    logic [19:0] acc;
    logic        busy16, done16, ovf16;
    logic [15:0] acc16;

    int vec = 0;
    int errs = 0;
    int ndone = 0;
    int ndone16 = 0;
    int d0;

    always #5 clk = ~clk;

    mac8_seq_ctrl #(.ACC_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .a(a), .b(b),
        .busy(busy), .done(done), .acc(acc), .ovf(ovf)
    );

    mac8_seq_ctrl #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .clr(clr), .a(a), .b(b),
        .busy(busy16), .done(done16), .acc(acc16), .ovf(ovf16)
    );

    always @(posedge clk) begin
        if (done)   ndone   <= ndone + 1;
        if (done16) ndone16 <= ndone16 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        @(negedge clk); clr = 1'b1;
        @(posedge clk);
        @(negedge clk); clr = 1'b0;
        chk("clr_acc", 32'(acc), 32'd0);
    endtask

    // Start at edge k, then check the busy/done timing through edge k+18.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input bit do_clr, input bit use16, input bit inject);
        bit early = 1'b0;
        @(negedge clk);
        a = x; b = y; clr = do_clr;
        if (use16) start16 = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; start16 = 1'b0; clr = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        chk("busy_k", 32'(use16 ? busy16 : busy), 32'd1);
        for (int n = 1; n <= 16; n++) begin
            if (inject && n == 5) begin
                start = 1'b1; a = 8'd200; b = 8'd200;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (use16 ? done16 : done) early = 1'b1;
            if (n == 16) chk("busy_k16", 32'(use16 ? busy16 : busy), 32'd1);
        end
        chk("early_done", 32'(early), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("done_k17", 32'(use16 ? done16 : done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("done_k18", 32'(use16 ? done16 : done), 32'd0);
        chk("busy_k18", 32'(use16 ? busy16 : busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start16 = 1'b0; clr = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst_acc",  32'(acc),  32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // Max operands
        run_op(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        chk("max_acc", 32'(acc), 32'd65025);
        chk("max_ovf", 32'(ovf), 32'd0);

        // Accumulate two products
        clear_acc();
        d0 = ndone;
        run_op(8'd3, 8'd2, 1'b0, 1'b0, 1'b0);
        chk("acc_first", 32'(acc), 32'd6);
        run_op(8'd13, 8'd11, 1'b0, 1'b0, 1'b0);
        chk("acc_second", 32'(acc), 32'd149);
        chk("acc_ndone", 32'(ndone - d0), 32'd2);

        // clr together with start starts from zero
        run_op(8'd4, 8'd5, 1'b1, 1'b0, 1'b0);
        chk("clrstart_acc", 32'(acc), 32'd20);
        chk("clrstart_ovf", 32'(ovf), 32'd0);

        // start while busy is dropped
        clear_acc();
        d0 = ndone;
        run_op(8'd3, 8'd2, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("busyrej_acc", 32'(acc), 32'd6);
        chk("busyrej_ndone", 32'(ndone - d0), 32'd1);
        chk("busyrej_busy", 32'(busy), 32'd0);

        // Reset at k+8 aborts the operation
        d0 = ndone;
        @(negedge clk); a = 8'd100; b = 8'd100; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("abort_acc",  32'(acc),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("abort_ndone", 32'(ndone - d0), 32'd0);
        run_op(8'd2, 8'd2, 1'b0, 1'b0, 1'b0);
        chk("abort_next_acc", 32'(acc), 32'd4);

        // 16-bit overflow
        run_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
        chk("ovf16_first_acc", 32'(acc16), 32'd65025);
        chk("ovf16_first_ovf", 32'(ovf16), 32'd0);
        run_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
`ifdef MAC8_SEQ_CTRL_SATURATE_EN
        chk("ovf16_acc", 32'(acc16), 32'd65535);
`else
        chk("ovf16_acc", 32'(acc16), 32'd64514);
`endif
        chk("ovf16_ovf", 32'(ovf16), 32'd1);
        chk("ovf16_ndone", 32'(ndone16), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
